// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator response engine: command and
// response codes, field widths and the request-queue entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int DATA_W   = 32;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = 2;
  localparam int CMD_W    = 4;
  localparam int RESP_W   = 2;
  localparam int SHAMT_W  = 5;
  localparam int NUM_REGS = 16;

  typedef enum logic [CMD_W-1:0] {
    NOP   = 4'd0,
    ADD   = 4'd1,
    SUB   = 4'd2,
    SHL   = 4'd5,
    SHR   = 4'd6,
    STORE = 4'd9,
    FETCH = 4'd10
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } resp_e;

  // The raw command code is kept (not cmd_e) so that undefined codes survive
  // the queue and can be answered with an error response.
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [IDX_W-1:0]  d1;
    logic [IDX_W-1:0]  d2;
    logic [IDX_W-1:0]  r1;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/calc_req_fifo.sv
// ---------------------------------------------------------------------------
// calc_req_fifo
// In-order request queue holding fifo_entry_t records.
// Ports:
//   clk_i    - rising-edge clock
//   rst_ni   - asynchronous active-low reset, empties the queue
//   push_i   - write wdata_i at the tail (ignored when full)
//   wdata_i  - entry to enqueue
//   pop_i    - remove the head (ignored when empty)
//   rdata_o  - current head entry
//   count_o  - number of stored entries
//   full_o   - count_o == DEPTH
//   empty_o  - count_o == 0
// ---------------------------------------------------------------------------
module calc_req_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  fifo_entry_t   wdata_i,
  input  logic          pop_i,
  output fifo_entry_t   rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/calc_resp_engine.sv
// ---------------------------------------------------------------------------
// calc_resp_engine
// Accepts calculator requests into an in-order queue and executes one queued
// request per clock against a 16 x 32-bit register file, returning a
// one-cycle response (code, tag, data) for every accepted request.
// Ports:
//   c_clk     - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   req_cmd   - command code, 0 = no request
//   req_d1/d2 - source register indices
//   req_r1    - destination register index
//   req_tag   - request tag, echoed on the response
//   req_data  - store operand
//   req_ready - a nonzero req_cmd is accepted at the next edge when 1
//   out_resp  - 0 none, 1 success, 2 error
//   out_tag   - tag of the response
//   out_data  - fetch result (0 for every other response)
// ---------------------------------------------------------------------------
module calc_resp_engine
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [IDX_W-1:0]  req_d1,
  input  logic [IDX_W-1:0]  req_d2,
  input  logic [IDX_W-1:0]  req_r1,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic [RESP_W-1:0] out_resp,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  fifo_entry_t       push_entry, head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [CW:0]       count_nxt;

  logic              req_ready_q, req_ready_d;
  resp_e             resp_q, resp_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] op_a, op_b, wr_val;
  logic [DATA_W:0]   sum;
  logic              wr_en;

  assign push_entry = '{cmd: req_cmd, d1: req_d1, d2: req_d2, r1: req_r1,
                        tag: req_tag, data: req_data};

  assign push = (req_cmd != '0) && req_ready_q && !fifo_full;
  assign pop  = !fifo_empty;

  calc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (c_clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready is registered from the post-edge occupancy so it is glitch-free
  // and stays low throughout reset.
  assign count_nxt   = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign req_ready_d = (count_nxt < DEPTH_C);

  assign op_a = regs_q[head.d1];
  assign op_b = regs_q[head.d2];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};

  // Execute the queue head: response code, echoed tag, fetch data and the
  // optional register write. Error cases never write the destination.
  always_comb begin
    resp_d = NONE;
    tag_d  = '0;
    data_d = '0;
    wr_en  = 1'b0;
    wr_val = '0;
    if (pop) begin
      tag_d = head.tag;
      case (head.cmd)
        ADD: begin
          if (sum[DATA_W]) begin
            resp_d = ERR;
          end else begin
            resp_d = OK;
            wr_en  = 1'b1;
            wr_val = sum[DATA_W-1:0];
          end
        end
        SUB: begin
          if (op_b > op_a) begin
            resp_d = ERR;
          end else begin
            resp_d = OK;
            wr_en  = 1'b1;
            wr_val = op_a - op_b;
          end
        end
        SHL: begin
          resp_d = OK;
          wr_en  = 1'b1;
          wr_val = op_a << op_b[SHAMT_W-1:0];
        end
        SHR: begin
          resp_d = OK;
          wr_en  = 1'b1;
          wr_val = op_a >> op_b[SHAMT_W-1:0];
        end
        STORE: begin
          resp_d = OK;
          wr_en  = 1'b1;
          wr_val = head.data;
        end
        FETCH: begin
          resp_d = OK;
          data_d = op_a;
        end
        default: resp_d = ERR;
      endcase
    end
  end

  // The write lands at the executing edge, so the next popped request
  // already sees it through op_a/op_b.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q <= 1'b0;
      resp_q      <= NONE;
      tag_q       <= '0;
      data_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      req_ready_q <= req_ready_d;
      resp_q      <= resp_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      if (wr_en) begin
        regs_q[head.r1] <= wr_val;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign out_resp  = resp_q;
  assign out_tag   = tag_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_calc_resp_engine.sv
// ---------------------------------------------------------------------------
// tb_calc_resp_engine
// Drives directed and randomized request streams into calc_resp_engine and
// checks every cycle against a queue/array model of the engine, plus literal
// expectations on the responses of the directed sequences.
// ---------------------------------------------------------------------------
module tb_calc_resp_engine;

  localparam int DEPTH = 4;

  logic        c_clk;
  logic        reset_n;
  logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
  logic [1:0]  req_tag;
  logic [31:0] req_data;
  logic        req_ready;
  logic [1:0]  out_resp, out_tag;
  logic [31:0] out_data;

  int vectors;
  int miscompares;
  int printed;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  r1;
    logic [1:0]  tag;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [1:0]  tag;
    logic [31:0] data;
  } rsp_t;

  req_t        mq[$];
  logic [31:0] mregs [16];
  logic [1:0]  exp_resp, exp_tag;
  logic [31:0] exp_data;
  logic        exp_ready;
  rsp_t        dut_log[$];

  calc_resp_engine #(.FIFO_DEPTH(DEPTH)) dut (
    .c_clk     (c_clk),
    .reset_n   (reset_n),
    .req_cmd   (req_cmd),
    .req_d1    (req_d1),
    .req_d2    (req_d2),
    .req_r1    (req_r1),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_resp  (out_resp),
    .out_tag   (out_tag),
    .out_data  (out_data)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (printed < 30) begin
        printed++;
        $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
    end
  endtask

  // Execute one request by the arithmetic rules of each command.
  task automatic modelExec(input req_t h);
    logic [31:0] a, b;
    longint unsigned s;
    a = mregs[h.d1];
    b = mregs[h.d2];
    exp_tag  = h.tag;
    exp_data = 32'h0;
    case (h.cmd)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) exp_resp = 2'd2;
        else begin exp_resp = 2'd1; mregs[h.r1] = s[31:0]; end
      end
      4'd2: begin
        if (b > a) exp_resp = 2'd2;
        else begin exp_resp = 2'd1; mregs[h.r1] = a - b; end
      end
      4'd5: begin exp_resp = 2'd1; mregs[h.r1] = a << (b % 32); end
      4'd6: begin exp_resp = 2'd1; mregs[h.r1] = a >> (b % 32); end
      4'd9: begin exp_resp = 2'd1; mregs[h.r1] = h.data; end
      4'd10: begin exp_resp = 2'd1; exp_data = a; end
      default: exp_resp = 2'd2;
    endcase
  endtask

  // Reference model: a queue of accepted requests and a register array.
  initial begin
    mq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
    exp_resp = 2'd0; exp_tag = 2'd0; exp_data = 32'h0; exp_ready = 1'b0;
    forever begin
      @(posedge c_clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
        exp_resp = 2'd0; exp_tag = 2'd0; exp_data = 32'h0; exp_ready = 1'b0;
      end else begin
        req_t h;
        logic accept;
        accept = (req_cmd != 4'd0) && exp_ready;
        exp_resp = 2'd0; exp_tag = 2'd0; exp_data = 32'h0;
        if (mq.size() > 0) begin
          h = mq.pop_front();
          modelExec(h);
        end
        if (accept) mq.push_back('{cmd: req_cmd, d1: req_d1, d2: req_d2, r1: req_r1,
                                   tag: req_tag, data: req_data});
        exp_ready = (mq.size() < DEPTH);
      end
    end
  end

  // Per-cycle compare away from the active edge; also logs DUT responses.
  initial begin
    forever begin
      @(negedge c_clk);
      cmpVal("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
      cmpVal("out_resp", {30'h0, out_resp}, {30'h0, exp_resp});
      cmpVal("out_tag", {30'h0, out_tag}, {30'h0, exp_tag});
      cmpVal("out_data", out_data, exp_data);
      if (out_resp != 2'd0) dut_log.push_back('{resp: out_resp, tag: out_tag, data: out_data});
    end
  end

  task automatic applyStimulus(input logic [3:0] cmd, input logic [3:0] d1, input logic [3:0] d2,
                               input logic [3:0] r1, input logic [1:0] tag, input logic [31:0] data);
    @(posedge c_clk);
    #2;
    req_cmd = cmd; req_d1 = d1; req_d2 = d2; req_r1 = r1; req_tag = tag; req_data = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #2;
      req_cmd = 4'd0;
    end
  endtask

  task automatic pulseReset();
    @(posedge c_clk);
    #2;
    reset_n = 1'b0;
    req_cmd = 4'd0;
    repeat (2) @(posedge c_clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [1:0] resp,
                             input logic [1:0] tag, input logic [31:0] data);
    if (idx >= dut_log.size()) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: response %0d missing, only %0d seen", name, idx, dut_log.size());
    end else begin
      cmpVal({name, ".resp"}, {30'h0, dut_log[idx].resp}, {30'h0, resp});
      cmpVal({name, ".tag"}, {30'h0, dut_log[idx].tag}, {30'h0, tag});
      cmpVal({name, ".data"}, dut_log[idx].data, data);
    end
  endtask

  initial begin
    logic [3:0] cmds [10];
    vectors = 0; miscompares = 0; printed = 0;
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd9, 4'd10, 4'd10, 4'd3, 4'd15};
    reset_n = 1'b0;
    req_cmd = 4'd0; req_d1 = 4'd0; req_d2 = 4'd0; req_r1 = 4'd0; req_tag = 2'd0; req_data = 32'h0;
    repeat (3) @(posedge c_clk);
    #2 reset_n = 1'b1;
    idle(2);

    // Store/store/add/fetch with back-to-back dependency.
    dut_log.delete();
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd3, 2'd0, 32'h10);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd4, 2'd1, 32'h05);
    applyStimulus(4'd1, 4'd3, 4'd4, 4'd5, 2'd2, 32'h0);
    applyStimulus(4'd10, 4'd5, 4'd0, 4'd0, 2'd3, 32'h0);
    idle(4);
    cmpVal("seq1_count", 32'(dut_log.size()), 32'd4);
    checkOutput("seq1_store3", 0, 2'd1, 2'd0, 32'h0);
    checkOutput("seq1_store4", 1, 2'd1, 2'd1, 32'h0);
    checkOutput("seq1_add", 2, 2'd1, 2'd2, 32'h0);
    checkOutput("seq1_fetch", 3, 2'd1, 2'd3, 32'h15);

    // Add overflow leaves the destination untouched.
    dut_log.delete();
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd1, 2'd0, 32'hFFFF_FFFF);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd2, 2'd1, 32'h1);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd6, 2'd2, 32'hAA);
    applyStimulus(4'd1, 4'd1, 4'd2, 4'd6, 2'd3, 32'h0);
    applyStimulus(4'd10, 4'd6, 4'd0, 4'd0, 2'd0, 32'h0);
    idle(4);
    checkOutput("ovf_add", 3, 2'd2, 2'd3, 32'h0);
    checkOutput("ovf_fetch", 4, 2'd1, 2'd0, 32'hAA);

    // Subtract borrow and success.
    dut_log.delete();
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd1, 2'd0, 32'd5);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd2, 2'd1, 32'd7);
    applyStimulus(4'd2, 4'd1, 4'd2, 4'd7, 2'd2, 32'h0);
    applyStimulus(4'd2, 4'd2, 4'd1, 4'd7, 2'd3, 32'h0);
    applyStimulus(4'd10, 4'd7, 4'd0, 4'd0, 2'd0, 32'h0);
    idle(4);
    checkOutput("sub_borrow", 2, 2'd2, 2'd2, 32'h0);
    checkOutput("sub_ok", 3, 2'd1, 2'd3, 32'h0);
    checkOutput("sub_fetch", 4, 2'd1, 2'd0, 32'd2);

    // Undefined commands error out without writing.
    dut_log.delete();
    applyStimulus(4'd3, 4'd1, 4'd2, 4'd1, 2'd1, 32'h0);
    applyStimulus(4'd15, 4'd1, 4'd2, 4'd2, 2'd2, 32'hDEAD);
    applyStimulus(4'd10, 4'd1, 4'd0, 4'd0, 2'd3, 32'h0);
    applyStimulus(4'd10, 4'd2, 4'd0, 4'd0, 2'd0, 32'h0);
    idle(4);
    checkOutput("bad_cmd3", 0, 2'd2, 2'd1, 32'h0);
    checkOutput("bad_cmd15", 1, 2'd2, 2'd2, 32'h0);
    checkOutput("bad_keep_r1", 2, 2'd1, 2'd3, 32'd5);
    checkOutput("bad_keep_r2", 3, 2'd1, 2'd0, 32'd7);

    // Six back-to-back requests with repeating tags come back in order.
    dut_log.delete();
    for (int i = 0; i < 6; i++) applyStimulus(4'd10, 4'd1, 4'd0, 4'd0, 2'(i % 4), 32'h0);
    idle(6);
    cmpVal("b2b_count", 32'(dut_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("b2b_%0d", i), i, 2'd1, 2'(i % 4), 32'd5);

    // Reset with requests in flight wipes queue and registers.
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd3, 2'd0, 32'h111);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd5, 2'd1, 32'h222);
    applyStimulus(4'd9, 4'd0, 4'd0, 4'd8, 2'd2, 32'h333);
    pulseReset();
    dut_log.delete();
    idle(2);
    applyStimulus(4'd10, 4'd3, 4'd0, 4'd0, 2'd1, 32'h0);
    applyStimulus(4'd10, 4'd5, 4'd0, 4'd0, 2'd2, 32'h0);
    applyStimulus(4'd10, 4'd8, 4'd0, 4'd0, 2'd3, 32'h0);
    idle(4);
    cmpVal("rst_count", 32'(dut_log.size()), 32'd3);
    checkOutput("rst_fetch_r3", 0, 2'd1, 2'd1, 32'h0);
    checkOutput("rst_fetch_r5", 1, 2'd1, 2'd2, 32'h0);
    checkOutput("rst_fetch_r8", 2, 2'd1, 2'd3, 32'h0);

    // Randomized traffic with idle gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom);
      if (r < 2) pulseReset();
      else if (r < 25) idle(1);
      else applyStimulus(cmds[$urandom_range(0, 9)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), d);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
